nano_cache_miss_ctrl: RTL and testbench

- Per-PE cache miss controller, directly upstream of the NanoCore cache update/arbitration stage.
- Accepts one line miss from the PE's cache lookup, writes back a dirty victim, then requests a refill read.
- Waits for the refilled line from the update stage and drives a single-cycle fill into the cache tag/data arrays.
- Also keeps saturating miss/writeback counters.

---
 rtl/nano_cache_pkg.sv | 35 +++
 rtl/nano_sat_cnt.sv | 31 +++
 rtl/nano_cache_miss_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_nano_cache_miss_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nano_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nano_cache_pkg
// Description : Shared types, constants and helpers for the NanoCore per-PE
//               cache miss controller (line type, FSM state encoding,
//               line-address alignment).
// Revision    : 1.0 - initial release
// ============================================================================
package nano_cache_pkg;

  // Byte-offset bits inside one 32-byte cache line.
  localparam int LINE_OFF_W = 5;

  // 32-bit words per line; matches the 256-bit memory data path.
  localparam int LINE_WORDS = 8;

  // One full cache line, word 0 in the least significant 32 bits.
  typedef logic [LINE_WORDS-1:0][31:0] line_t;

  // Miss-handling FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WB_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_FILL    = 3'd4
  } miss_state_e;

  // Clear the byte-offset bits so the address points at the line base.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return {addr[31:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/nano_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : nano_sat_cnt
// Description : Saturating up-counter with increment enable. Sticks at the
//               all-ones value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module nano_sat_cnt #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled events, holding at the maximum value once reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/nano_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nano_cache_miss_ctrl
// Description : Per-PE cache miss controller. Accepts one line miss, writes
//               back a dirty victim, issues the refill read, waits for the
//               refilled line (with timeout/retry) and drives a one-cycle
//               fill into the cache arrays. Keeps saturating miss and
//               writeback counters.
// Revision    : 1.0 - initial release
// ============================================================================
module nano_cache_miss_ctrl #(
  parameter int LINE_WORDS = 8,   // fixed: 256-bit memory data path
  parameter int INDEX_W    = 6,   // set index = addr[5+INDEX_W-1:5]
  parameter int TIMEOUT    = 64   // RD_WAIT cycles before a retry, >= 4
) (
  input  logic                                                i_clk,
  input  logic                                                i_rst,
  // Miss request from the cache lookup
  input  logic                                                i_miss_valid,
  input  logic [31:0]                                         i_miss_addr,
  input  logic                                                i_victim_dirty,
  input  logic [31:0]                                         i_victim_addr,
  input  logic [LINE_WORDS-1:0][31:0]                         i_victim_data,
  output logic                                                o_miss_ready,
  // Requests to the update/arbitration stage
  output logic                                                o_miss_rden,
  output logic                                                o_miss_wren,
  output logic [31:0]                                         o_miss_addr,
  output logic [LINE_WORDS-1:0][31:0]                         o_miss_wdata,
  input  logic                                                i_miss_resp,
  output logic                                                o_wb_wren,
  input  logic                                                i_wb_gnt,
  // Refill data from the update stage
  input  logic                                                i_upd_valid,
  input  logic [LINE_WORDS-1:0][31:0]                         i_upd_rdata,
  // Fill into the cache tag/data arrays
  output logic                                                o_fill_valid,
  output logic [INDEX_W-1:0]                                  o_fill_index,
  output logic [31-nano_cache_pkg::LINE_OFF_W-INDEX_W:0]      o_fill_tag,
  output logic [LINE_WORDS-1:0][31:0]                         o_fill_data,
  // Status
  output logic                                                o_busy,
  output logic                                                o_timeout_err,
  output logic [31:0]                                         o_miss_cnt,
  output logic [31:0]                                         o_wb_cnt
);

  import nano_cache_pkg::*;

  localparam int TAG_W = 32 - LINE_OFF_W - INDEX_W;
  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] C_TIMER_LAST = TMR_W'(TIMEOUT - 1);

  miss_state_e        r_state;
  logic [31:0]        r_line_addr;
  logic [TMR_W-1:0]   r_timer;
  logic               r_busy;
  logic               r_miss_rden;
  logic               r_wb_wren;
  logic [31:0]        r_miss_addr;
  line_t              r_miss_wdata;
  logic               r_fill_valid;
  logic [INDEX_W-1:0] r_fill_index;
  logic [TAG_W-1:0]   r_fill_tag;
  line_t              r_fill_data;
  logic               r_timeout_err;

  logic               w_miss_accept;
  logic               w_wb_done;

  // A miss is accepted only while idle; one transaction in flight at a time.
  assign w_miss_accept = (r_state == ST_IDLE) && i_miss_valid;
  // A writeback completes when the grant arrives while it is being requested.
  assign w_wb_done     = (r_state == ST_WB_REQ) && i_wb_gnt;

  // Miss FSM: state plus every registered output, updated on transitions.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_line_addr   <= '0;
      r_timer       <= '0;
      r_busy        <= 1'b0;
      r_miss_rden   <= 1'b0;
      r_wb_wren     <= 1'b0;
      r_miss_addr   <= '0;
      r_miss_wdata  <= '0;
      r_fill_valid  <= 1'b0;
      r_fill_index  <= '0;
      r_fill_tag    <= '0;
      r_fill_data   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_miss_valid) begin
            r_line_addr <= line_align(i_miss_addr);
            r_busy      <= 1'b1;
            if (i_victim_dirty) begin
              // Victim must reach memory before the refill is requested.
              r_state      <= ST_WB_REQ;
              r_wb_wren    <= 1'b1;
              r_miss_addr  <= i_victim_addr;
              r_miss_wdata <= i_victim_data;
            end else begin
              r_state      <= ST_RD_REQ;
              r_miss_rden  <= 1'b1;
              r_miss_addr  <= line_align(i_miss_addr);
              r_miss_wdata <= '0;
            end
          end
        end

        ST_WB_REQ: begin
          // Request is held for as long as the grant is withheld.
          if (i_wb_gnt) begin
            r_state      <= ST_RD_REQ;
            r_wb_wren    <= 1'b0;
            r_miss_rden  <= 1'b1;
            r_miss_addr  <= r_line_addr;
            r_miss_wdata <= '0;
          end
        end

        ST_RD_REQ: begin
          if (i_miss_resp) begin
            r_state     <= ST_RD_WAIT;
            r_miss_rden <= 1'b0;
            r_miss_addr <= '0;
            r_timer     <= '0;
          end
        end

        ST_RD_WAIT: begin
          // Valid data takes priority over an expiring timer.
          if (i_upd_valid) begin
            r_state      <= ST_FILL;
            r_fill_valid <= 1'b1;
            r_fill_data  <= i_upd_rdata;
            r_fill_index <= r_line_addr[LINE_OFF_W +: INDEX_W];
            r_fill_tag   <= r_line_addr[31 -: TAG_W];
          end else if (r_timer == C_TIMER_LAST) begin
            r_state       <= ST_RD_REQ;
            r_timeout_err <= 1'b1;
            r_miss_rden   <= 1'b1;
            r_miss_addr   <= r_line_addr;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        ST_FILL: begin
          // Fill strobe lasts one cycle; release the PE stall afterwards.
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_fill_valid <= 1'b0;
          r_fill_index <= '0;
          r_fill_tag   <= '0;
          r_fill_data  <= '0;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_busy       <= 1'b0;
          r_miss_rden  <= 1'b0;
          r_wb_wren    <= 1'b0;
          r_fill_valid <= 1'b0;
        end
      endcase
    end
  end

  // Accepted-miss counter.
  nano_sat_cnt #(
    .WIDTH (32)
  ) u_miss_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_miss_accept),
    .o_count (o_miss_cnt)
  );

  // Granted-writeback counter.
  nano_sat_cnt #(
    .WIDTH (32)
  ) u_wb_cnt (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_wb_done),
    .o_count (o_wb_cnt)
  );

  assign o_miss_ready  = w_miss_accept;
  assign o_miss_rden   = r_miss_rden;
  assign o_miss_wren   = 1'b0;
  assign o_miss_addr   = r_miss_addr;
  assign o_miss_wdata  = r_miss_wdata;
  assign o_wb_wren     = r_wb_wren;
  assign o_fill_valid  = r_fill_valid;
  assign o_fill_index  = r_fill_index;
  assign o_fill_tag    = r_fill_tag;
  assign o_fill_data   = r_fill_data;
  assign o_busy        = r_busy;
  assign o_timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_nano_cache_miss_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_nano_cache_miss_ctrl
// Description : Directed self-checking bench for nano_cache_miss_ctrl
//               (TIMEOUT overridden to 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nano_cache_miss_ctrl;

  import nano_cache_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_miss_valid;
  logic [31:0] i_miss_addr;
  logic        i_victim_dirty;
  logic [31:0] i_victim_addr;
  line_t       i_victim_data;
  logic        o_miss_ready;
  logic        o_miss_rden;
  logic        o_miss_wren;
  logic [31:0] o_miss_addr;
  line_t       o_miss_wdata;
  logic        i_miss_resp;
  logic        o_wb_wren;
  logic        i_wb_gnt;
  logic        i_upd_valid;
  line_t       i_upd_rdata;
  logic        o_fill_valid;
  logic [5:0]  o_fill_index;
  logic [20:0] o_fill_tag;
  line_t       o_fill_data;
  logic        o_busy;
  logic        o_timeout_err;
  logic [31:0] o_miss_cnt;
  logic [31:0] o_wb_cnt;

  int n_err = 0;
  int n_chk = 0;

  line_t d_clean;
  line_t d_dirty;
  line_t d_a5;
  line_t d_tmo;

  nano_cache_miss_ctrl #(
    .LINE_WORDS (8),
    .INDEX_W    (6),
    .TIMEOUT    (8)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_miss_valid   (i_miss_valid),
    .i_miss_addr    (i_miss_addr),
    .i_victim_dirty (i_victim_dirty),
    .i_victim_addr  (i_victim_addr),
    .i_victim_data  (i_victim_data),
    .o_miss_ready   (o_miss_ready),
    .o_miss_rden    (o_miss_rden),
    .o_miss_wren    (o_miss_wren),
    .o_miss_addr    (o_miss_addr),
    .o_miss_wdata   (o_miss_wdata),
    .i_miss_resp    (i_miss_resp),
    .o_wb_wren      (o_wb_wren),
    .i_wb_gnt       (i_wb_gnt),
    .i_upd_valid    (i_upd_valid),
    .i_upd_rdata    (i_upd_rdata),
    .o_fill_valid   (o_fill_valid),
    .o_fill_index   (o_fill_index),
    .o_fill_tag     (o_fill_tag),
    .o_fill_data    (o_fill_data),
    .o_busy         (o_busy),
    .o_timeout_err  (o_timeout_err),
    .o_miss_cnt     (o_miss_cnt),
    .o_wb_cnt       (o_wb_cnt)
  );

  always #5 i_clk = ~i_clk;

  // Advance one clock and settle past the edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full clean miss: accept, same-cycle resp, data on the next RD_WAIT cycle.
  task automatic clean_miss(input logic [31:0] addr);
    i_miss_valid = 1'b1; i_miss_addr = addr; i_victim_dirty = 1'b0;
    tick();
    i_miss_valid = 1'b0; i_miss_resp = 1'b1;
    tick();
    i_miss_resp = 1'b0; i_upd_valid = 1'b1; i_upd_rdata = d_clean;
    tick();
    i_upd_valid = 1'b0;
    chk("sat_fill_valid", o_fill_valid, 1'b1);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      d_clean[i] = 32'(i);
      d_dirty[i] = 32'h100 + 32'(i);
      d_a5[i]    = 32'hA5A5_A5A5;
      d_tmo[i]   = 32'hC000_0000 + 32'(i);
    end
    i_rst = 1'b1; i_miss_valid = 1'b0; i_miss_addr = '0; i_victim_dirty = 1'b0;
    i_victim_addr = '0; i_victim_data = '0; i_miss_resp = 1'b0; i_wb_gnt = 1'b0;
    i_upd_valid = 1'b0; i_upd_rdata = '0;
    tick(); tick();
    i_rst = 1'b0;

    // Reset state
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_rden", o_miss_rden, 1'b0);
    chk("rst_wb_wren", o_wb_wren, 1'b0);
    chk("rst_fill_valid", o_fill_valid, 1'b0);
    chk("rst_miss_addr", o_miss_addr, 32'h0);
    chk("rst_miss_cnt", o_miss_cnt, 32'h0);
    chk("rst_err", o_timeout_err, 1'b0);
    chk("rst_miss_ready", o_miss_ready, 1'b0);

    // Clean miss: 0x1234 -> line 0x1220, index 0x11, tag 0x2; resp held high
    i_miss_valid = 1'b1; i_miss_addr = 32'h0000_1234; i_victim_dirty = 1'b0;
    i_miss_resp = 1'b1;
    #1;
    chk("c_ready", o_miss_ready, 1'b1);
    tick();
    i_miss_valid = 1'b0;
    chk("c_rden", o_miss_rden, 1'b1);
    chk("c_addr", o_miss_addr, 32'h0000_1220);
    chk("c_wdata0", o_miss_wdata, 256'h0);
    chk("c_wren_tied", o_miss_wren, 1'b0);
    chk("c_busy", o_busy, 1'b1);
    chk("c_miss_cnt", o_miss_cnt, 32'd1);
    tick();
    chk("c_wait_rden", o_miss_rden, 1'b0);
    tick();
    i_upd_valid = 1'b1; i_upd_rdata = d_clean;
    tick();
    i_upd_valid = 1'b0;
    chk("c_fill_valid", o_fill_valid, 1'b1);
    chk("c_fill_index", o_fill_index, 6'h11);
    chk("c_fill_tag", o_fill_tag, 21'h2);
    chk("c_fill_data", o_fill_data, d_clean);
    tick();
    chk("c_fill_once", o_fill_valid, 1'b0);
    chk("c_busy_drop", o_busy, 1'b0);
    chk("c_wb_cnt", o_wb_cnt, 32'd0);
    i_miss_resp = 1'b0;

    // Dirty miss: victim 0x8020 / A5 data, grant after 3 cycles
    i_miss_valid = 1'b1; i_miss_addr = 32'h0000_4010; i_victim_dirty = 1'b1;
    i_victim_addr = 32'h0000_8020; i_victim_data = d_a5;
    tick();
    i_miss_valid = 1'b0; i_victim_dirty = 1'b0; i_victim_data = '0;
    for (int i = 0; i < 3; i++) begin
      chk("d_wb_wren_hold", o_wb_wren, 1'b1);
      chk("d_wb_wdata", o_miss_wdata, d_a5);
      chk("d_wb_addr", o_miss_addr, 32'h0000_8020);
      chk("d_no_rden", o_miss_rden, 1'b0);
      tick();
    end
    chk("d_wb_cnt_pre", o_wb_cnt, 32'd0);
    i_wb_gnt = 1'b1;
    chk("d_wb_wren_4th", o_wb_wren, 1'b1);
    tick();
    chk("d_wb_wren_off", o_wb_wren, 1'b0);
    chk("d_rden", o_miss_rden, 1'b1);
    chk("d_rd_addr", o_miss_addr, 32'h0000_4000);
    chk("d_rd_wdata0", o_miss_wdata, 256'h0);
    chk("d_wb_cnt", o_wb_cnt, 32'd1);
    // Grant still high here is stray and must not count
    i_miss_resp = 1'b1;
    tick();
    i_wb_gnt = 1'b0; i_miss_resp = 1'b0;
    chk("d_stray_gnt", o_wb_cnt, 32'd1);
    i_upd_valid = 1'b1; i_upd_rdata = d_dirty;
    tick();
    i_upd_valid = 1'b0;
    chk("d_fill_valid", o_fill_valid, 1'b1);
    chk("d_fill_index", o_fill_index, 6'h00);
    chk("d_fill_tag", o_fill_tag, 21'h8);
    chk("d_fill_data", o_fill_data, d_dirty);
    tick();
    chk("d_miss_cnt", o_miss_cnt, 32'd2);

    // Timeout: 8 RD_WAIT cycles without data, then retry
    i_miss_valid = 1'b1; i_miss_addr = 32'h0000_0064;
    tick();
    i_miss_valid = 1'b0; i_miss_resp = 1'b1;
    tick();
    i_miss_resp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t_wait_rden", o_miss_rden, 1'b0);
      chk("t_wait_err", o_timeout_err, 1'b0);
      tick();
    end
    chk("t_err", o_timeout_err, 1'b1);
    chk("t_retry_rden", o_miss_rden, 1'b1);
    chk("t_retry_addr", o_miss_addr, 32'h0000_0060);
    // Stray valid in RD_REQ is ignored
    i_upd_valid = 1'b1; i_upd_rdata = d_tmo;
    tick();
    chk("t_stray_valid", o_fill_valid, 1'b0);
    chk("t_still_rden", o_miss_rden, 1'b1);
    i_upd_valid = 1'b0; i_miss_resp = 1'b1;
    tick();
    i_miss_resp = 1'b0; i_upd_valid = 1'b1;
    tick();
    i_upd_valid = 1'b0;
    chk("t_fill_valid", o_fill_valid, 1'b1);
    chk("t_fill_data", o_fill_data, d_tmo);
    chk("t_err_sticky", o_timeout_err, 1'b1);
    tick();

    // Valid arrives in the very cycle the timer expires: fill wins
    i_miss_valid = 1'b1; i_miss_addr = 32'h0000_00A0;
    tick();
    i_miss_valid = 1'b0; i_miss_resp = 1'b1;
    tick();
    i_miss_resp = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    i_upd_valid = 1'b1; i_upd_rdata = d_dirty;
    tick();
    i_upd_valid = 1'b0;
    chk("s_fill_valid", o_fill_valid, 1'b1);
    chk("s_no_retry", o_miss_rden, 1'b0);
    chk("s_fill_index", o_fill_index, 6'h05);
    tick();
    chk("s_idle", o_busy, 1'b0);

    // Reset during RD_WAIT, data arrives right after
    i_miss_valid = 1'b1; i_miss_addr = 32'h0000_0100;
    tick();
    i_miss_valid = 1'b0; i_miss_resp = 1'b1;
    tick();
    i_miss_resp = 1'b0;
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0; i_upd_valid = 1'b1; i_upd_rdata = d_clean;
    chk("r_busy", o_busy, 1'b0);
    chk("r_rden", o_miss_rden, 1'b0);
    chk("r_err", o_timeout_err, 1'b0);
    chk("r_miss_cnt", o_miss_cnt, 32'd0);
    chk("r_wb_cnt", o_wb_cnt, 32'd0);
    tick();
    i_upd_valid = 1'b0;
    chk("r_no_fill", o_fill_valid, 1'b0);
    chk("r_no_fill_data", o_fill_data, 256'h0);
    i_miss_valid = 1'b1; i_miss_addr = 32'h0000_0200;
    #1;
    chk("r_ready_again", o_miss_ready, 1'b1);
    tick();
    i_miss_valid = 1'b0; i_miss_resp = 1'b1;
    chk("r_miss_cnt_new", o_miss_cnt, 32'd1);
    tick();
    i_miss_resp = 1'b0; i_upd_valid = 1'b1;
    tick();
    i_upd_valid = 1'b0;
    tick();

    // Saturation: preload the miss counter near the top
    force dut.u_miss_cnt.r_count = 32'hFFFF_FFFE;
    #1;
    release dut.u_miss_cnt.r_count;
    clean_miss(32'h0000_0300);
    chk("sat_first", o_miss_cnt, 32'hFFFF_FFFF);
    clean_miss(32'h0000_0320);
    clean_miss(32'h0000_0340);
    chk("sat_hold", o_miss_cnt, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
